pipe_addsub_param: RTL and testbench
====================================

// Module: pipe_addsub_param
// PURPOSE
//  Parametrised pipelined ripple-carry adder/subtractor with valid/ready flow control.
//  WIDTH-bit operands are processed in CHUNK-bit slices, one slice per pipeline stage.
//  Carry is registered between stages; operand slices are skewed, and result slices de-skewed.
//  Drop-in arithmetic stage for datapaths that need throughput of one op/clock and backpressure.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise)
//  CHUNK   4  bits added per stage; NSTAGE = WIDTH/CHUNK (localparam, >=1)
// PORTS
//  Clk        in   1      rising-edge clock
//  Rst        in   1      synchronous, active-high reset
//  In_valid   in   1      A/B/Cin/Sub carry a valid operation
//  In_ready   out  1      block can accept an operation this cycle
//  A          in   WIDTH  operand A (unsigned or two's complement)
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add) / borrow-in (sub)
//  Sub        in   1      0: A+B+Cin   1: A-B-Cin
//  Out_valid  out  1      Sum/Cout/Ovf hold a valid result
//  Out_ready  in   1      downstream accepts the result this cycle
//  Sum        out  WIDTH  result
//  Cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//  Ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Arithmetic: Bx = B ^ {WIDTH{Sub}}, c0 = Cin ^ Sub; {Cout,Sum} = A + Bx + c0, all mod 2^(WIDTH+1).
//  - Stage k (0..NSTAGE-1) adds slice k of A and Bx plus the registered carry from stage k-1.
//    Stage 0 uses c0. Each stage then registers its slice sum, carry, and the remaining operand slices.
//  - Global enable: en = ~Out_valid | Out_ready; In_ready = en (combinational, no dependence on In_valid).
//  - Transfer in: In_valid & In_ready at edge t. Transfer out: Out_valid & Out_ready.
//  - Latency: an op accepted at edge t is presented on Sum/Cout/Ovf with Out_valid=1
//    from edge t+NSTAGE-1 onward (NSTAGE=1: right after edge t). Throughput: 1 op/clock when unstalled.
//  - Per-stage valid bit shifts with en; bubbles (In_valid=0) propagate as valid=0 and are never emitted.
//  - When en=0: every stage register holds, and Sum/Cout/Ovf/Out_valid stay stable. No op is lost or duplicated.
//  - Stall with bubbles: bubbles are not collapsed (global stall); order is always preserved.
//  - Rst=1 at an edge: all valid bits are cleared and Sum=0, Cout=0, Ovf=0.
//    In-flight ops are discarded; In_ready=1 in the first cycle after reset (Out_valid=0).
//  - Rst takes priority over en and over any simultaneous input transfer (that op is dropped).
//  - Data registers of invalid stages may hold don't-care values, but the outputs are reset to 0 as stated.
//  - Wrap-around: Sum is modulo 2^WIDTH; the carry/borrow is reported only through Cout and Ovf.
// TESTING (WIDTH=8, CHUNK=4 unless noted; NSTAGE=2)
//  1 A=7,B=5,Cin=0,Sub=0, single op -> Sum=12,Cout=0,Ovf=0; Out_valid exactly 1 edge after accept edge.
//  2 A=255,B=1,Cin=0 -> Sum=0,Cout=1,Ovf=0; A=127,B=0,Cin=1 -> Sum=128,Cout=0,Ovf=1.
//  3 Sub=1: A=5,B=7,Cin=0 -> Sum=0xFE,Cout=0,Ovf=0; A=0x80,B=1,Cin=0 -> Sum=0x7F,Cout=1,Ovf=1;
//    A=9,B=4,Cin=1 -> Sum=4,Cout=1.
//  4 4 back-to-back ops (7+5, 10+6, 4+10+1, 0+6+1), Out_ready=1 ->
//    results 12,16,15,7 on consecutive cycles, in order.
//  5 Out_ready=0 for 3 cycles while ops are in flight -> In_ready=0, outputs frozen;
//    after release all ops emerge in order with none lost or duplicated.
//  6 Rst asserted with 2 ops in flight -> Out_valid=0 and Sum=0 after that edge; neither op ever emerges.
//    Rerun tests 1-3 with WIDTH=8, CHUNK=8 (NSTAGE=1; result right after the accept edge).

Source files
------------

// File: rtl/pipe_addsub_param.sv
// pipe_addsub_param
//   Pipelined ripple-carry adder/subtractor. WIDTH-bit operands are split
//   into CHUNK-bit slices; stage k adds slice k and hands its carry to
//   stage k+1 through a register. Operand slices not yet consumed travel
//   down the pipe (skew), and finished result slices accumulate alongside
//   (de-skew), so the last stage register holds the complete result.
//   A single global enable stalls every stage at once.
//
// Ports
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset (clears valids and outputs)
//   In_valid   operation on A/B/Cin/Sub is valid
//   In_ready   block accepts an operation this cycle (= global enable)
//   A, B       WIDTH-bit operands
//   Cin        carry-in for add, borrow-in for subtract
//   Sub        0: A+B+Cin, 1: A-B-Cin
//   Out_valid  Sum/Cout/Ovf hold a valid result
//   Out_ready  downstream accepts the result this cycle
//   Sum        WIDTH-bit result, modulo 2^WIDTH
//   Cout       carry out of MSB (subtract: 1 = no borrow)
//   Ovf        signed overflow (carry into MSB xor carry out of MSB)

module pipe_addsub_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NSTAGE = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("pipe_addsub_param: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic en;

  always_comb begin
    en       = ~Out_valid | Out_ready;
    In_ready = en;
  end

  // Each stage sees only the operand slices it and later stages still need
  // (REM bits, current slice at the bottom) and the result bits finished so
  // far; this keeps every register bit live.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned REM  = WIDTH - k * CHUNK;
    localparam int unsigned DONE = (k + 1) * CHUNK;

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  bx_in;
    logic            c_in;
    logic            v_in;
    logic [CHUNK:0]  slice;
    logic [DONE-1:0] sum_nxt;

    logic [DONE-1:0] sum_q;
    logic            c_q;
    logic            v_q;

    if (k == 0) begin : g_head
      always_comb begin
        a_in  = A;
        bx_in = B ^ {WIDTH{Sub}};
        c_in  = Cin ^ Sub;
        v_in  = In_valid;
      end
      always_comb begin
        slice   = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bx_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
        sum_nxt = slice[CHUNK-1:0];
      end
    end else begin : g_link
      always_comb begin
        a_in  = g_stage[k-1].g_fwd.a_q;
        bx_in = g_stage[k-1].g_fwd.bx_q;
        c_in  = g_stage[k-1].c_q;
        v_in  = g_stage[k-1].v_q;
      end
      always_comb begin
        slice   = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bx_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
        sum_nxt = {slice[CHUNK-1:0], g_stage[k-1].sum_q};
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= slice[CHUNK];
        sum_q <= sum_nxt;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] bx_q;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (en) begin
          a_q  <= a_in[REM-1:CHUNK];
          bx_q <= bx_in[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;
      logic ovf_nxt;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_comb begin
        ovf_nxt = a_in[REM-1] ^ bx_in[REM-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
      end

      always_ff @(posedge Clk) begin
        if (Rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_nxt;
        end
      end

      always_comb begin
        Sum       = sum_q;
        Cout      = c_q;
        Ovf       = ovf_q;
        Out_valid = v_q;
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub_param.sv
// tb_pipe_addsub_param
//   Drives two instances side by side with shared inputs: WIDTH=8/CHUNK=4
//   (two stages) and WIDTH=8/CHUNK=8 (one stage). Fixed vectors check
//   values and latency; hand sequences cover stall and reset; a random run
//   is checked by per-instance scoreboards fed from a signed/unsigned
//   integer arithmetic model.

module tb_pipe_addsub_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, cin, sub, out_ready;
  logic [7:0] a, b;

  logic       rdy_a, ov_a, cout_a, ovf_a;
  logic [7:0] sum_a;
  logic       rdy_b, ov_b, cout_b, ovf_b;
  logic [7:0] sum_b;

  int checks = 0;
  int errors = 0;

  pipe_addsub_param #(.WIDTH(8), .CHUNK(4)) dut_a (
    .Clk(clk), .Rst(rst), .In_valid(in_valid), .In_ready(rdy_a),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .Out_valid(ov_a), .Out_ready(out_ready),
    .Sum(sum_a), .Cout(cout_a), .Ovf(ovf_a)
  );

  pipe_addsub_param #(.WIDTH(8), .CHUNK(8)) dut_b (
    .Clk(clk), .Rst(rst), .In_valid(in_valid), .In_ready(rdy_b),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .Out_valid(ov_b), .Out_ready(out_ready),
    .Sum(sum_b), .Cout(cout_b), .Ovf(ovf_b)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  res_t qa[$];
  res_t qb[$];

  // Plain integer arithmetic: unsigned result gives Sum/Cout, signed
  // result out of range gives Ovf.
  function automatic res_t model(logic [7:0] x, logic [7:0] y, logic ci, logic s);
    res_t r;
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      r.cout = (ur > 255);
    end else begin
      ur = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      r.cout = (ur >= 0);
    end
    r.sum = ur[7:0];
    r.ovf = (sr > 127) || (sr < -128);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    sub = v.sub;
  endtask

  // Scoreboards: handshakes are observed on the falling edge, i.e. what
  // the next rising edge will commit.
  always @(negedge clk) begin
    res_t got, exp;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ov_a && out_ready) begin
        checks++;
        got = {sum_a, cout_a, ovf_a};
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a spurious result got=%0h exp=none at %0t", got, $time);
        end else begin
          exp = qa.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_a got=%0h exp=%0h at %0t", got, exp, $time);
          end
        end
      end
      if (ov_b && out_ready) begin
        checks++;
        got = {sum_b, cout_b, ovf_b};
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b spurious result got=%0h exp=none at %0t", got, $time);
        end else begin
          exp = qb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_b got=%0h exp=%0h at %0t", got, exp, $time);
          end
        end
      end
      if (in_valid && rdy_a) qa.push_back(model(a, b, cin, sub));
      if (in_valid && rdy_b) qb.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  vec_t singles[8];
  vec_t burst[4];
  vec_t stall_ops[3];
  vec_t rst_ops[3];

  initial begin
    singles[0] = '{8'd7,   8'd5, 1'b0, 1'b0, 8'd12,  1'b0, 1'b0};
    singles[1] = '{8'd255, 8'd1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    singles[2] = '{8'd127, 8'd0, 1'b1, 1'b0, 8'd128, 1'b0, 1'b1};
    singles[3] = '{8'd5,   8'd7, 1'b0, 1'b1, 8'hFE,  1'b0, 1'b0};
    singles[4] = '{8'h80,  8'd1, 1'b0, 1'b1, 8'h7F,  1'b1, 1'b1};
    singles[5] = '{8'd9,   8'd4, 1'b1, 1'b1, 8'd4,   1'b1, 1'b0};
    singles[6] = '{8'h80,  8'h80, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1};
    singles[7] = '{8'd0,   8'd0, 1'b1, 1'b1, 8'hFF,  1'b0, 1'b0};

    burst[0] = '{8'd7,  8'd5,  1'b0, 1'b0, 8'd12, 1'b0, 1'b0};
    burst[1] = '{8'd10, 8'd6,  1'b0, 1'b0, 8'd16, 1'b0, 1'b0};
    burst[2] = '{8'd4,  8'd10, 1'b1, 1'b0, 8'd15, 1'b0, 1'b0};
    burst[3] = '{8'd0,  8'd6,  1'b1, 1'b0, 8'd7,  1'b0, 1'b0};

    stall_ops[0] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    stall_ops[1] = '{8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
    stall_ops[2] = '{8'h40, 8'h41, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1};

    rst_ops[0] = '{8'h90, 8'h90, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1};
    rst_ops[1] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    rst_ops[2] = '{8'h05, 8'h05, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov_a",  32'(ov_a),   32'd0);
    check("rst_sum_a", 32'(sum_a),  32'd0);
    check("rst_cout_a", 32'(cout_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a),  32'd0);
    check("rst_rdy_a", 32'(rdy_a),  32'd1);
    check("rst_ov_b",  32'(ov_b),   32'd0);
    check("rst_sum_b", 32'(sum_b),  32'd0);
    rst = 1'b0;

    // Single ops: one-stage instance shows the result right after the
    // accept edge, two-stage instance one edge later.
    foreach (singles[i]) begin
      drive(singles[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("single_ov_b",   32'(ov_b),   32'd1);
      check("single_sum_b",  32'(sum_b),  32'(singles[i].sum));
      check("single_cout_b", 32'(cout_b), 32'(singles[i].cout));
      check("single_ovf_b",  32'(ovf_b),  32'(singles[i].ovf));
      check("single_early_a", 32'(ov_a),  32'd0);
      @(posedge clk); #1;
      check("single_ov_a",   32'(ov_a),   32'd1);
      check("single_sum_a",  32'(sum_a),  32'(singles[i].sum));
      check("single_cout_a", 32'(cout_a), 32'(singles[i].cout));
      check("single_ovf_a",  32'(ovf_a),  32'(singles[i].ovf));
      check("single_done_b", 32'(ov_b),   32'd0);
      @(posedge clk); #1;
      check("single_done_a", 32'(ov_a),   32'd0);
    end

    // Back-to-back burst with no backpressure.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive(burst[i]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 4) check("burst_sum_b", 32'(sum_b), 32'(burst[i].sum));
      if (i >= 1 && i <= 4) begin
        check("burst_ov_a",  32'(ov_a),  32'd1);
        check("burst_sum_a", 32'(sum_a), 32'(burst[i-1].sum));
      end else begin
        check("burst_idle_a", 32'(ov_a), 32'd0);
      end
    end
    in_valid = 1'b0;

    // Downstream stall with ops in flight.
    out_ready = 1'b0;
    drive(stall_ops[0]); in_valid = 1'b1;
    @(posedge clk); #1;
    check("stall_fill_ov_a", 32'(ov_a), 32'd0);
    drive(stall_ops[1]);
    @(posedge clk); #1;
    check("stall_ov_a",  32'(ov_a),  32'd1);
    check("stall_sum_a", 32'(sum_a), 32'(stall_ops[0].sum));
    check("stall_rdy_a", 32'(rdy_a), 32'd0);
    drive(stall_ops[2]);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("stall_hold_rdy_a", 32'(rdy_a), 32'd0);
      check("stall_hold_ov_a",  32'(ov_a),  32'd1);
      check("stall_hold_sum_a", 32'(sum_a), 32'(stall_ops[0].sum));
      check("stall_hold_rdy_b", 32'(rdy_b), 32'd0);
      check("stall_hold_sum_b", 32'(sum_b), 32'(stall_ops[0].sum));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_sum_a1", 32'(sum_a), 32'(stall_ops[1].sum));
    check("release_ov_a1",  32'(ov_a),  32'd1);
    @(posedge clk); #1;
    check("release_sum_a2", 32'(sum_a), 32'(stall_ops[2].sum));
    check("release_ovf_a2", 32'(ovf_a), 32'(stall_ops[2].ovf));
    @(posedge clk); #1;
    check("release_empty_a", 32'(ov_a), 32'd0);
    check("release_empty_b", 32'(ov_b), 32'd0);

    // Reset with two ops in flight and a third offered at the reset edge.
    out_ready = 1'b0;
    drive(rst_ops[0]); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(rst_ops[1]);
    @(posedge clk); #1;
    check("prerst_ov_a",  32'(ov_a),  32'd1);
    check("prerst_sum_a", 32'(sum_a), 32'(rst_ops[0].sum));
    rst = 1'b1;
    drive(rst_ops[2]);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("midrst_ov_a",   32'(ov_a),   32'd0);
    check("midrst_sum_a",  32'(sum_a),  32'd0);
    check("midrst_cout_a", 32'(cout_a), 32'd0);
    check("midrst_ovf_a",  32'(ovf_a),  32'd0);
    check("midrst_rdy_a",  32'(rdy_a),  32'd1);
    check("midrst_ov_b",   32'(ov_b),   32'd0);
    check("midrst_sum_b",  32'(sum_b),  32'd0);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      check("postrst_ov_a", 32'(ov_a), 32'd0);
      check("postrst_ov_b", 32'(ov_b), 32'd0);
    end

    // Random traffic with random backpressure, scoreboard-checked.
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
